control_sequencer: RTL and testbench



---
 rtl/control_defs.sv | 49 ++++
 rtl/reg_decoder_4to16.sv | 12 +
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/control_defs.sv
// rtl/control_defs.sv - shared opcodes, IR field positions and state encoding for control_sequencer
package control_defs;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  // Groups opcodes by the shape of their execute phase.
  function automatic op_class_t op_class(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_ALU3;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// rtl/reg_decoder_4to16.sv - 4-bit register index to one-hot enable vector
module reg_decoder_4to16 #(
  parameter int REGISTERS = 16
) (
  input  logic [3:0]           idx,
  input  logic                 en,
  output logic [REGISTERS-1:0] onehot
);

  assign onehot = en ? (REGISTERS'(1) << idx) : '0;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute control unit for the datapath
module control_sequencer
  import control_defs::*;
#(
  parameter int REGISTERS = 16,
  parameter int BITS      = 32
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic [BITS-1:0]      IR,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 RZin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 RYin,
  output logic                 HIin,
  output logic                 LOin,
  output logic [REGISTERS-1:0] Rin,
  output logic [REGISTERS-1:0] Rout,
  output logic                 ADD,
  output logic                 SUB,
  output logic                 MUL,
  output logic                 DIV,
  output logic                 SHR,
  output logic                 SHL,
  output logic                 ROR,
  output logic                 ROL,
  output logic                 AND,
  output logic                 OR,
  output logic                 NEGATE,
  output logic                 NOT,
  output logic                 Halted,
  output logic                 IllegalOp
);

  state_t    state, next_state;
  op_class_t cls;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc, rout_idx;
  logic       rout_en, rin_en, alu_en;
  logic       unused_ir;

  assign opcode    = IR[OPC_MSB:OPC_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign cls       = op_class(opcode);
  assign unused_ir = ^IR[RC_LSB-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    {PCout, MARin, IncPC, RZin, Zlowout, Zhighout, PCin} = '0;
    {Read, MDRin, MDRout, IRin, RYin, HIin, LOin}        = '0;
    rout_en   = 1'b0;
    rout_idx  = rb;
    rin_en    = 1'b0;
    alu_en    = 1'b0;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      ST_IDLE: if (Run) next_state = ST_T0;
      ST_T0: begin
        {PCout, MARin, IncPC, RZin} = 4'b1111;
        next_state = ST_T1;
      end
      ST_T1: begin
        {Zlowout, PCin, Read, MDRin} = 4'b1111;
        next_state = ST_T2;
      end
      ST_T2: begin
        {MDRout, IRin} = 2'b11;
        case (cls)
          CLS_NOP:  next_state = Run ? ST_T0 : ST_IDLE;
          CLS_HALT: next_state = ST_HALT;
          default:  next_state = ST_T3;
        endcase
      end
      ST_T3: begin
        case (cls)
          CLS_ALU3, CLS_MULDIV: begin
            rout_en    = 1'b1;
            RYin       = 1'b1;
            next_state = ST_T4;
          end
          CLS_UNARY: begin
            rout_en    = 1'b1;
            alu_en     = 1'b1;
            RZin       = 1'b1;
            next_state = ST_T4;
          end
          default: begin
            IllegalOp  = 1'b1;
            next_state = Run ? ST_T0 : ST_IDLE;
          end
        endcase
      end
      ST_T4: begin
        if (cls == CLS_UNARY) begin
          Zlowout    = 1'b1;
          rin_en     = 1'b1;
          next_state = Run ? ST_T0 : ST_IDLE;
        end else begin
          rout_en    = 1'b1;
          rout_idx   = rc;
          alu_en     = 1'b1;
          RZin       = 1'b1;
          next_state = ST_T5;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin       = 1'b1;
          next_state = ST_T6;
        end else begin
          rin_en     = 1'b1;
          next_state = Run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        {Zhighout, HIin} = 2'b11;
        next_state = Run ? ST_T0 : ST_IDLE;
      end
      ST_HALT: Halted = 1'b1;
      default: next_state = ST_IDLE;
    endcase
  end

  // Only one ALU select can match since the opcode is compared against distinct constants.
  assign ADD    = alu_en && (opcode == OP_ADD);
  assign SUB    = alu_en && (opcode == OP_SUB);
  assign MUL    = alu_en && (opcode == OP_MUL);
  assign DIV    = alu_en && (opcode == OP_DIV);
  assign SHR    = alu_en && (opcode == OP_SHR);
  assign SHL    = alu_en && (opcode == OP_SHL);
  assign ROR    = alu_en && (opcode == OP_ROR);
  assign ROL    = alu_en && (opcode == OP_ROL);
  assign AND    = alu_en && (opcode == OP_AND);
  assign OR     = alu_en && (opcode == OP_OR);
  assign NEGATE = alu_en && (opcode == OP_NEG);
  assign NOT    = alu_en && (opcode == OP_NOT);

  reg_decoder_4to16 #(.REGISTERS(REGISTERS)) u_rin_dec (
    .idx    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_decoder_4to16 #(.REGISTERS(REGISTERS)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn, Run;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, RZin, Zlowout, Zhighout, PCin;
  logic        Read, MDRin, MDRout, IRin, RYin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic        ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
  logic        Halted, IllegalOp;

  int vectors = 0;
  int miscompares = 0;

  // Strobe bit order: PCout MARin IncPC RZin Zlowout Zhighout PCin Read MDRin MDRout IRin RYin HIin LOin
  localparam logic [13:0] SB_T0 = 14'h3C00;
  localparam logic [13:0] SB_T1 = 14'h02E0;
  localparam logic [13:0] SB_T2 = 14'h0018;
  localparam logic [13:0] SB_RY = 14'h0004;
  localparam logic [13:0] SB_RZ = 14'h0400;
  localparam logic [13:0] SB_ZL = 14'h0200;
  localparam logic [13:0] SB_ZH = 14'h0100;
  localparam logic [13:0] SB_HI = 14'h0002;
  localparam logic [13:0] SB_LO = 14'h0001;
  // ALU order: ADD SUB MUL DIV SHR SHL ROR ROL AND OR NEGATE NOT
  localparam logic [11:0] A_ADD = 12'h800;
  localparam logic [11:0] A_MUL = 12'h200;
  localparam logic [11:0] A_NEG = 12'h002;

  localparam logic [31:0] IR_ADD  = 32'h18918000;
  localparam logic [31:0] IR_MUL  = 32'h722B0000;
  localparam logic [31:0] IR_NEG  = 32'h83C00000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  control_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
    .Halted(Halted), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [13:0] es, input logic [11:0] ea,
                       input logic [15:0] ein, input logic [15:0] eout,
                       input logic eh, input logic ei);
    logic [59:0] obs, exp;
    obs = {PCout, MARin, IncPC, RZin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, RYin, HIin, LOin,
           ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
           Rin, Rout, Halted, IllegalOp};
    exp = {es, ea, ein, eout, eh, ei};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    check({tag, "_t0"}, SB_T0, '0, '0, '0, 1'b0, 1'b0); tick();
    check({tag, "_t1"}, SB_T1, '0, '0, '0, 1'b0, 1'b0); tick();
    check({tag, "_t2"}, SB_T2, '0, '0, '0, 1'b0, 1'b0); tick();
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b1;
    IR     = IR_ADD;
    repeat (3) tick();
    check("reset_idle", '0, '0, '0, '0, 1'b0, 1'b0);
    Resetn = 1'b1;
    tick();

    // add R1,R2,R3 then back-to-back mul
    fetch("add");
    check("add_t3", SB_RY, '0, '0, 16'h0004, 1'b0, 1'b0); tick();
    check("add_t4", SB_RZ, A_ADD, '0, 16'h0008, 1'b0, 1'b0); tick();
    check("add_t5", SB_ZL, '0, 16'h0002, '0, 1'b0, 1'b0); tick();
    IR = IR_MUL;
    fetch("mul");
    check("mul_t3", SB_RY, '0, '0, 16'h0020, 1'b0, 1'b0); tick();
    check("mul_t4", SB_RZ, A_MUL, '0, 16'h0040, 1'b0, 1'b0); tick();
    check("mul_t5", SB_ZL | SB_LO, '0, '0, '0, 1'b0, 1'b0); tick();
    check("mul_t6", SB_ZH | SB_HI, '0, '0, '0, 1'b0, 1'b0); tick();

    // neg R7,R8 with Run dropped in T3
    IR = IR_NEG;
    fetch("neg");
    check("neg_t3", SB_RZ, A_NEG, '0, 16'h0100, 1'b0, 1'b0);
    Run = 1'b0;
    tick();
    check("neg_t4", SB_ZL, '0, 16'h0080, '0, 1'b0, 1'b0); tick();
    check("neg_idle", '0, '0, '0, '0, 1'b0, 1'b0); tick();
    check("idle_hold", '0, '0, '0, '0, 1'b0, 1'b0);

    // nop (3 cycles) then illegal opcode (4 cycles)
    IR  = IR_NOP;
    Run = 1'b1;
    tick();
    fetch("nop");
    IR = IR_ILL;
    fetch("ill");
    check("ill_t3", '0, '0, '0, '0, 1'b0, 1'b1); tick();
    check("ill_next_t0", SB_T0, '0, '0, '0, 1'b0, 1'b0);

    // fault-free reset during T4 of add: outputs clear in the same cycle
    IR = IR_ADD;
    tick(); tick(); tick();
    check("rst_add_t3", SB_RY, '0, '0, 16'h0004, 1'b0, 1'b0); tick();
    check("rst_add_t4", SB_RZ, A_ADD, '0, 16'h0008, 1'b0, 1'b0);
    #2 Resetn = 1'b0;
    #1 check("rst_async", '0, '0, '0, '0, 1'b0, 1'b0);
    tick();
    check("rst_no_rin", '0, '0, '0, '0, 1'b0, 1'b0);
    Resetn = 1'b1;
    tick();
    check("rst_restart_t0", SB_T0, '0, '0, '0, 1'b0, 1'b0);

    // halt holds with Run high
    IR = IR_HALT;
    tick(); tick();
    check("halt_t2", SB_T2, '0, '0, '0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 20; i++) begin
      check("halted", '0, '0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    Resetn = 1'b0;
    #1 check("halt_reset", '0, '0, '0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
